// File: rtl/oc_wormhole_arbiter.sv
// Purpose: wormhole output-channel arbiter. Round-robin grant, held until tail or watchdog, drives crossbar select.
// Latency: request seen in IDLE -> grant/sel/busy registered next cycle; oc_vld_o is combinational from sel and vld_i.
// Backpressure: oc_rdy_i low stalls transfers; the grant and flit count hold with no stall timeout.
module oc_wormhole_arbiter #(
    parameter int IN_N      = 5,
    parameter int IDX_W     = 3,
    parameter int MAX_FLITS = 16,
    parameter int CNT_W     = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [IN_N-1:0]  req_i,
    input  logic [IN_N-1:0]  vld_i,
    input  logic [IN_N-1:0]  tail_i,
    input  logic             oc_rdy_i,
    output logic [IN_N-1:0]  grant_o,
    output logic [IDX_W-1:0] sel_o,
    output logic             oc_vld_o,
    output logic             busy_o,
    output logic             err_o
);

    typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   sel_q, sel_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IN_N-1:0]    grant_q, grant_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;

    logic               owner_vld, owner_tail;
    logic               xfer, at_limit;
    logic               found;
    logic [IDX_W-1:0]   winner;
    logic [2*IN_N-1:0]  req_rot;
    logic [IDX_W:0]     scan_pos;

    // Pick the owning VC's valid and tail bits (crossbar-side view of the owner)
    always_comb begin
        owner_vld  = 1'b0;
        owner_tail = 1'b0;
        for (int i = 0; i < IN_N; i++) begin
            if (sel_q == IDX_W'(i)) begin
                owner_vld  = vld_i[i];
                owner_tail = tail_i[i];
            end
        end
    end

    // Round-robin scan: first requester at or above rr_ptr, wrapping modulo IN_N
    always_comb begin
        found    = 1'b0;
        winner   = '0;
        scan_pos = '0;
        req_rot  = {req_i, req_i} >> rr_ptr_q;
        for (int k = 0; k < IN_N; k++) begin
            if (!found && req_rot[k]) begin
                found    = 1'b1;
                scan_pos = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
                if (scan_pos >= (IDX_W+1)'(IN_N)) begin
                    scan_pos = scan_pos - (IDX_W+1)'(IN_N);
                end
                winner = scan_pos[IDX_W-1:0];
            end
        end
    end

    assign xfer     = (state_q == ST_LOCKED) && owner_vld && oc_rdy_i;
    assign at_limit = (cnt_q == CNT_W'(MAX_FLITS - 1));

    // Next-state: arbitrate only in IDLE; release on tail or watchdog limit
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    state_d = ST_LOCKED;
                    sel_d   = winner;
                    cnt_d   = '0;
                    grant_d = '0;
                    for (int i = 0; i < IN_N; i++) begin
                        if (winner == IDX_W'(i)) grant_d[i] = 1'b1;
                    end
                end
            end
            ST_LOCKED: begin
                if (xfer) begin
                    if (owner_tail || at_limit) begin
                        state_d  = ST_IDLE;
                        grant_d  = '0;
                        sel_d    = '0;
                        // explicit wrap: IN_N need not be a power of two
                        rr_ptr_d = (sel_q == IDX_W'(IN_N - 1)) ? '0 : sel_q + IDX_W'(1);
                        // a tail on the limit flit is a normal release
                        if (!owner_tail) err_d = 1'b1;
                    end else if (!at_limit) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers with synchronous active-high reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            sel_q    <= '0;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

    assign grant_o  = grant_q;
    assign sel_o    = sel_q;
    assign busy_o   = (state_q == ST_LOCKED);
    assign err_o    = err_q;
    assign oc_vld_o = busy_o & owner_vld;

endmodule

// File: tb/tb_oc_wormhole_arbiter.sv
// Purpose: self-checking bench for oc_wormhole_arbiter: vector table, directed corner sequences, random vs packet-level model.
// Latency: one step per clock; registered outputs compared 1ns after the rising edge, oc_vld_o just before it.
// Backpressure: oc_rdy_i is driven as stimulus; the model only counts flits accepted while ready.
module tb_oc_wormhole_arbiter;

    localparam int IN_N      = 5;
    localparam int IDX_W     = 3;
    localparam int MAX_FLITS = 16;
    localparam int CNT_W     = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic [IN_N-1:0]  req, vld, tail;
    logic             rdy;
    logic [IN_N-1:0]  grant;
    logic [IDX_W-1:0] sel;
    logic             ovld, busy, err;

    oc_wormhole_arbiter #(
        .IN_N(IN_N), .IDX_W(IDX_W), .MAX_FLITS(MAX_FLITS), .CNT_W(CNT_W)
    ) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .vld_i(vld), .tail_i(tail),
        .oc_rdy_i(rdy), .grant_o(grant), .sel_o(sel), .oc_vld_o(ovld),
        .busy_o(busy), .err_o(err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Packet-level model: who owns the channel, where the round-robin pointer sits,
    // how many flits the current packet has moved, and whether the watchdog ever fired.
    int m_owner = -1;
    int m_rr    = 0;
    int m_flits = 0;
    bit m_err   = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0d, required %0d", nm, cyc, act, exp);
        end
    endtask

    task automatic model_clock(input logic r, input logic [IN_N-1:0] rq, vd, tl, input logic rd);
        if (r) begin
            m_owner = -1; m_rr = 0; m_flits = 0; m_err = 1'b0;
        end else if (m_owner < 0) begin
            for (int k = 0; k < IN_N; k++) begin
                int c;
                c = (m_rr + k) % IN_N;
                if (rq[c]) begin
                    m_owner = c;
                    m_flits = 0;
                    break;
                end
            end
        end else if (vd[m_owner] && rd) begin
            m_flits++;
            if (tl[m_owner] || m_flits >= MAX_FLITS) begin
                if (!tl[m_owner]) m_err = 1'b1;
                m_rr    = (m_owner + 1) % IN_N;
                m_owner = -1;
            end
        end
    endtask

    // One clock: drive, check oc_vld_o before the edge, clock, advance model, check registers.
    task automatic step(input logic r, input logic [IN_N-1:0] rq, vd, tl, input logic rd,
                        output logic ovld_seen);
        logic [IN_N-1:0] eg;
        rst = r; req = rq; vld = vd; tail = tl; rdy = rd;
        #1;
        ovld_seen = ovld;
        chk("model_oc_vld", int'(ovld), int'(m_owner >= 0 && vd[m_owner]));
        @(posedge clk);
        model_clock(r, rq, vd, tl, rd);
        #1;
        cyc++;
        eg = '0;
        if (m_owner >= 0) eg[m_owner] = 1'b1;
        chk("model_grant", int'(grant), int'(eg));
        chk("model_sel",   int'(sel),   (m_owner >= 0) ? m_owner : 0);
        chk("model_busy",  int'(busy),  int'(m_owner >= 0));
        chk("model_err",   int'(err),   int'(m_err));
    endtask

    typedef struct packed {
        logic             r;
        logic [IN_N-1:0]  rq, vd, tl;
        logic             rd;
        logic             e_ovld;
        logic [IN_N-1:0]  e_grant;
        logic [IDX_W-1:0] e_sel;
        logic             e_busy;
    } vec_t;

    vec_t vec[12];
    logic ov;

    initial begin
        rst = 1'b1; req = '0; vld = '0; tail = '0; rdy = 1'b0;

        // basic grant/release of VC2, then pointer walk 3 -> 4 -> wrap to 0
        vec[0]  = '{1'b0, 5'b00100, 5'b00000, 5'b00000, 1'b1, 1'b0, 5'b00100, 3'd2, 1'b1};
        vec[1]  = '{1'b0, 5'b00100, 5'b00100, 5'b00000, 1'b1, 1'b1, 5'b00100, 3'd2, 1'b1};
        vec[2]  = '{1'b0, 5'b00100, 5'b00100, 5'b00000, 1'b1, 1'b1, 5'b00100, 3'd2, 1'b1};
        vec[3]  = '{1'b0, 5'b00100, 5'b00100, 5'b00000, 1'b1, 1'b1, 5'b00100, 3'd2, 1'b1};
        vec[4]  = '{1'b0, 5'b00100, 5'b00100, 5'b00100, 1'b1, 1'b1, 5'b00000, 3'd0, 1'b0};
        vec[5]  = '{1'b0, 5'b00000, 5'b00000, 5'b00000, 1'b1, 1'b0, 5'b00000, 3'd0, 1'b0};
        vec[6]  = '{1'b0, 5'b11111, 5'b00000, 5'b00000, 1'b1, 1'b0, 5'b01000, 3'd3, 1'b1};
        vec[7]  = '{1'b0, 5'b00000, 5'b01000, 5'b01000, 1'b1, 1'b1, 5'b00000, 3'd0, 1'b0};
        vec[8]  = '{1'b0, 5'b11111, 5'b00000, 5'b00000, 1'b1, 1'b0, 5'b10000, 3'd4, 1'b1};
        vec[9]  = '{1'b0, 5'b00000, 5'b10000, 5'b10000, 1'b1, 1'b1, 5'b00000, 3'd0, 1'b0};
        vec[10] = '{1'b0, 5'b11111, 5'b00000, 5'b00000, 1'b1, 1'b0, 5'b00001, 3'd0, 1'b1};
        vec[11] = '{1'b0, 5'b00000, 5'b00001, 5'b00001, 1'b1, 1'b1, 5'b00000, 3'd0, 1'b0};

        step(1'b1, '0, '0, '0, 1'b0, ov);
        chk("reset_busy", int'(busy), 0);
        chk("reset_grant", int'(grant), 0);
        chk("reset_sel", int'(sel), 0);
        chk("reset_err", int'(err), 0);
        chk("reset_oc_vld", int'(ovld), 0);

        for (int i = 0; i < 12; i++) begin
            step(vec[i].r, vec[i].rq, vec[i].vd, vec[i].tl, vec[i].rd, ov);
            chk($sformatf("vec%0d_oc_vld", i), int'(ov), int'(vec[i].e_ovld));
            chk($sformatf("vec%0d_grant", i), int'(grant), int'(vec[i].e_grant));
            chk($sformatf("vec%0d_sel", i), int'(sel), int'(vec[i].e_sel));
            chk($sformatf("vec%0d_busy", i), int'(busy), int'(vec[i].e_busy));
            chk($sformatf("vec%0d_err", i), int'(err), 0);
        end

        // round-robin fairness: all request, 2-flit packets, order 0,1,2,3,4,0
        step(1'b1, '0, '0, '0, 1'b0, ov);
        for (int p = 0; p < 6; p++) begin
            logic [IN_N-1:0] b;
            b = '0; b[p % IN_N] = 1'b1;
            step(1'b0, 5'b11111, 5'b00000, 5'b00000, 1'b1, ov);
            chk("rr_order_sel", int'(sel), p % IN_N);
            step(1'b0, 5'b11111, b, 5'b00000, 1'b1, ov);
            step(1'b0, 5'b11111, b, b, 1'b1, ov);
            chk("rr_release_busy", int'(busy), 0);
        end

        // backpressure: VC1 3-flit packet stalled 5 cycles after the first flit
        step(1'b1, '0, '0, '0, 1'b0, ov);
        step(1'b0, 5'b00010, 5'b00000, 5'b00000, 1'b1, ov);
        step(1'b0, 5'b00010, 5'b00010, 5'b00000, 1'b1, ov);
        for (int s = 0; s < 5; s++) begin
            step(1'b0, 5'b00010, 5'b00010, 5'b00000, 1'b0, ov);
            chk("bp_oc_vld", int'(ov), 1);
            chk("bp_grant_held", int'(grant), 2);
        end
        step(1'b0, 5'b00010, 5'b00010, 5'b00000, 1'b1, ov);
        chk("bp_still_busy", int'(busy), 1);
        step(1'b0, 5'b00010, 5'b00010, 5'b00010, 1'b1, ov);
        chk("bp_release", int'(busy), 0);

        // lock isolation: VC3 intrudes, VC0 drops req before its tail
        step(1'b1, '0, '0, '0, 1'b0, ov);
        step(1'b0, 5'b00001, 5'b00000, 5'b00000, 1'b1, ov);
        step(1'b0, 5'b01001, 5'b01001, 5'b00000, 1'b1, ov);
        chk("iso_sel_hold", int'(sel), 0);
        step(1'b0, 5'b01000, 5'b01001, 5'b01000, 1'b1, ov);
        chk("iso_sel_hold_noreq", int'(sel), 0);
        chk("iso_busy_noreq", int'(busy), 1);
        step(1'b0, 5'b01000, 5'b01001, 5'b00001, 1'b1, ov);
        chk("iso_release", int'(busy), 0);
        step(1'b0, 5'b01000, 5'b01000, 5'b00000, 1'b1, ov);
        chk("iso_vc3_grant", int'(grant), 8);

        // watchdog: VC4 sends 16 flits with no tail
        step(1'b1, '0, '0, '0, 1'b0, ov);
        step(1'b0, 5'b10000, 5'b00000, 5'b00000, 1'b1, ov);
        for (int f = 0; f < MAX_FLITS; f++) begin
            chk("wd_busy_before", int'(busy), 1);
            step(1'b0, 5'b10000, 5'b10000, 5'b00000, 1'b1, ov);
        end
        chk("wd_release", int'(busy), 0);
        chk("wd_err_set", int'(err), 1);
        step(1'b0, 5'b11111, 5'b00000, 5'b00000, 1'b1, ov);
        chk("wd_rr_wrap_sel", int'(sel), 0);
        chk("wd_err_sticky", int'(err), 1);

        // watchdog limit coinciding with tail: normal release, no error
        step(1'b1, '0, '0, '0, 1'b0, ov);
        step(1'b0, 5'b10000, 5'b00000, 5'b00000, 1'b1, ov);
        for (int f = 0; f < MAX_FLITS; f++) begin
            step(1'b0, 5'b10000, 5'b10000, (f == MAX_FLITS-1) ? 5'b10000 : 5'b00000, 1'b1, ov);
        end
        chk("wdtail_release", int'(busy), 0);
        chk("wdtail_no_err", int'(err), 0);

        // reset mid-packet: VC2 locked after 3 flits
        step(1'b0, 5'b00100, 5'b00000, 5'b00000, 1'b1, ov);
        for (int f = 0; f < 3; f++) step(1'b0, 5'b00100, 5'b00100, 5'b00000, 1'b1, ov);
        chk("rst_pre_busy", int'(busy), 1);
        step(1'b1, 5'b00100, 5'b00100, 5'b00000, 1'b1, ov);
        chk("rst_busy", int'(busy), 0);
        chk("rst_grant", int'(grant), 0);
        chk("rst_sel", int'(sel), 0);
        step(1'b0, 5'b00100, 5'b00000, 5'b00000, 1'b1, ov);
        chk("rst_regrant", int'(grant), 4);

        // random traffic against the model, with occasional resets
        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(0, 299) == 0),
                 IN_N'($urandom), IN_N'($urandom),
                 ($urandom_range(0, 3) == 0) ? IN_N'($urandom) : '0,
                 ($urandom_range(0, 3) != 0), ov);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/oc_wormhole_arbiter.md
# oc_wormhole_arbiter

Per-output-port arbiter that shares one router output channel among IN_N input virtual channels under wormhole switching. It grants the channel to one requesting VC by round-robin, then holds the grant until that VC's tail flit has transferred. It drives the crossbar select, and it enforces a maximum packet length with a watchdog. One instance sits at each router output port, between the VCs' per-output request bits and the crossbar/output buffer.

## Interface
- IN_N, 5, number of requesting VCs/input ports
- IDX_W, 3, width of select index; must satisfy 2**IDX_W >= IN_N
- MAX_FLITS, 16, maximum transfers per granted packet (header included) before forced release
- CNT_W, 5, flit counter width; must satisfy 2**CNT_W > MAX_FLITS

- clk_i  in  1  single clock; all state updates on rising edge
- rst_i  in  1  synchronous, active-high reset
- req_i  in  IN_N  VC i requests this output; asserted only while VC i holds an unserved header or an active packet
- vld_i  in  IN_N  VC i presents a valid flit on its data output this cycle
- tail_i  in  IN_N  flit presented by VC i is a tail flit
- oc_rdy_i  in  1  downstream buffer can accept a flit this cycle
- grant_o  out  IN_N  one-hot grant to the owning VC; all-zero when not busy
- sel_o  out  IDX_W  crossbar select = index of owning VC; 0 when not busy
- oc_vld_o  out  1  busy & vld_i[sel_o]; combinational
- busy_o  out  1  output channel is locked to a VC
- err_o  out  1  sticky: watchdog fired since reset

## Operation
- FSM states:
  - IDLE: no owner.
  - LOCKED: owner = sel_o.
- Transfer event: xfer = LOCKED & vld_i[sel_o] & tail_i-independent & oc_rdy_i.
- IDLE -> LOCKED: when req_i != 0. Winner is the first set bit of req_i scanning upward from rr_ptr, wrapping modulo IN_N. Register sel_o = winner, set grant_o one-hot, clear flit_cnt.
- LOCKED -> IDLE on either condition:
  - xfer & tail_i[sel_o] (normal release).
  - xfer with flit_cnt == MAX_FLITS-1 and no tail (watchdog release). This also sets err_o.
- On any release, rr_ptr <= (sel_o+1) mod IN_N. The wrap is explicit, because IN_N need not be a power of two.
- In LOCKED, flit_cnt increments on each xfer and saturates at MAX_FLITS-1.
- Changes to req_i and vld_i of non-owner VCs are ignored while LOCKED.
- Owner req_i deassertion while LOCKED is ignored; the lock holds until tail or watchdog.
- The IDLE state's req_i scan only occurs in IDLE. The release cycle never re-arbitrates, so there is exactly one IDLE cycle between packets.
- err_o is cleared only by rst_i.
- Reset values: state IDLE, rr_ptr 0, flit_cnt 0, grant_o 0, sel_o 0, busy_o 0, err_o 0, oc_vld_o 0.

## Timing
- Grant latency:
  - req_i seen in IDLE at cycle t -> grant_o, busy_o, sel_o valid from cycle t+1.
  - The first header transfer can happen at t+1 if vld_i and oc_rdy_i are high.
- grant_o, sel_o, busy_o and err_o are registered. oc_vld_o is a combinational mux of registered sel_o and vld_i.
- Tail transfer at cycle t -> busy_o=0, grant_o=0 at t+1. The earliest next grant is at t+2.
- oc_rdy_i low with owner valid: no xfer, flit_cnt holds, grant holds indefinitely. There is no timeout on stall; the watchdog counts transfers, not cycles.
- Simultaneous tail and watchdog limit on the same xfer: treat as a normal release; err_o is not set.
- Single-flit packet (header flagged tail): released after one xfer.
- rst_i asserted mid-packet: all state returns to reset values on the next edge. The grant drops immediately, with no tail required.

## Test plan
- Basic grant and release:
  - Stimulus: reset, then req_i=00100 at cycle 0; vld_i[2]=1 and oc_rdy_i=1 from cycle 1; tail_i[2] on the 4th flit (cycle 4).
  - Required: grant_o=00100 and sel_o=2 during cycles 1–4; busy_o=0 at cycle 5; rr_ptr=3; err_o=0.
- Round-robin fairness:
  - Stimulus: req_i=11111 held constant; each owner sends a 2-flit packet.
  - Required: grant order 0,1,2,3,4,0 with exactly one idle cycle between grants.
- Backpressure:
  - Stimulus: owner VC1 in a 3-flit packet; oc_rdy_i=0 for 5 cycles mid-packet.
  - Required: oc_vld_o follows vld_i[1], grant held throughout, flit_cnt frozen; release occurs 1 cycle after the tail xfer once oc_rdy_i=1.
- Lock isolation:
  - Stimulus: VC0 owns; VC3 raises req_i and vld_i mid-packet; VC0 drops req_i before its tail.
  - Required: sel_o stays 0 until VC0's tail xfer; VC3 is granted 2 cycles after that tail.
- Watchdog:
  - Stimulus: MAX_FLITS=16; owner VC4 sends 16 flits without tail.
  - Required: release after the 16th xfer, err_o=1 and sticky, rr_ptr=0 (wrap from 4 with IN_N=5).
  - Stimulus: repeat with the tail on the 16th flit.
  - Required: err_o stays 0.
- Reset mid-packet:
  - Stimulus: rst_i asserted for 1 cycle while VC2 is LOCKED with flit_cnt=3.
  - Required: next cycle busy_o=0, grant_o=0, sel_o=0, err_o=0; with req_i=00100 still high, VC2 is re-granted one cycle later (rr_ptr=0 scan).
